// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR           = 32'd4;

  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_FLUSH = 2'd1,
    IFID_HOLD  = 2'd2
  } ifid_action_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Instruction addresses are word aligned; drop the low two bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection (redirect > stall > +4).
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_c
);

  logic [XLEN-1:0] pc_next_c;

  // Sequential successor; wraps modulo 2^32 naturally.
  always_comb begin
    pc_plus4_c = pc_o + PC_INCR;
  end

  // A redirect wins over a stall so a resolved branch is never lost.
  always_comb begin
    pc_next_c = pc_plus4_c;
    if (pc_src_i) begin
      pc_next_c = align_pc(pc_target_i);
    end else if (stall_i) begin
      pc_next_c = pc_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= RESET_PC;
    end else begin
      pc_o <= pc_next_c;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, optional
// performance counters enabled by the IF_STAGE_PERF_CNT_EN macro.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus4_o,
  output logic            id_valid_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic [XLEN-1:0] stall_cnt_o
);

  logic [XLEN-1:0] pc_plus4_c;
  ifid_action_t    action_c;
  ifid_t           ifid_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .pc_src_i    (pc_src_i),
    .pc_target_i (pc_target_i),
    .pc_o        (pc_o),
    .pc_plus4_c  (pc_plus4_c)
  );

  // Flush beats stall: a squashed slot must become a bubble even when frozen.
  always_comb begin
    action_c = IFID_LOAD;
    if (flush_i) begin
      action_c = IFID_FLUSH;
    end else if (stall_i) begin
      action_c = IFID_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
    end else begin
      case (action_c)
        IFID_LOAD: begin
          ifid_q.instr    <= instr_i;
          ifid_q.pc       <= pc_o;
          ifid_q.pc_plus4 <= pc_plus4_c;
          ifid_q.valid    <= 1'b1;
        end
        IFID_FLUSH: begin
          ifid_q.instr    <= NOP_INSTR;
          ifid_q.pc       <= pc_o;
          ifid_q.pc_plus4 <= pc_plus4_c;
          ifid_q.valid    <= 1'b0;
        end
        default: begin
          ifid_q <= ifid_q;
        end
      endcase
    end
  end

  assign id_instr_o    = ifid_q.instr;
  assign id_pc_o       = ifid_q.pc;
  assign id_pc_plus4_o = ifid_q.pc_plus4;
  assign id_valid_o    = ifid_q.valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] stall_cnt_q;

  // Free-running event counters; wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (action_c == IFID_LOAD) begin
        fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      end
      if (action_c == IFID_HOLD) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table plus randomized
// run against a behavioural model. Honours IF_STAGE_PERF_CNT_EN.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, pc_src_i;
  logic [31:0] pc_target_i, pc_o, instr_i;
  logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o, fetch_cnt_o, stall_cnt_o;
  logic        id_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory: a deterministic word per address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign instr_i = mem(pc_o);

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .pc_src_i      (pc_src_i),
    .pc_target_i   (pc_target_i),
    .pc_o          (pc_o),
    .instr_i       (instr_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_valid_o    (id_valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef IF_STAGE_PERF_CNT_EN
    return c;
`else
    return (c & 32'h0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, flush, src;
    logic [31:0] tgt;
    logic [31:0] pc, id_pc, id_p4;
    logic        valid;
    logic [31:0] fcnt, scnt;
  } vec_t;

  vec_t vecs[14];

  // Model state (architectural view, not the RTL's registers)
  logic [31:0] m_pc, m_instr, m_idpc, m_idp4, m_fc, m_sc;
  logic        m_valid;

  task automatic drive(input logic r, input logic s, input logic f, input logic p,
                       input logic [31:0] t);
    rst = r; stall_i = s; flush_i = f; pc_src_i = p; pc_target_i = t;
    @(posedge clk);
    #1;
  endtask

  // What one rising edge does, stated from the requirement rules
  task automatic model_step(input logic r, input logic s, input logic f, input logic p,
                            input logic [31:0] t);
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_idpc = 0; m_idp4 = 0; m_valid = 0;
      m_fc = 0; m_sc = 0;
      return;
    end
    if (f) begin
      m_instr = NOP; m_valid = 0; m_idpc = fetched_pc; m_idp4 = fetched_pc + 4;
    end else if (!s) begin
      m_instr = mem(fetched_pc); m_valid = 1; m_idpc = fetched_pc; m_idp4 = fetched_pc + 4;
      m_fc = m_fc + 1;
    end else begin
      m_sc = m_sc + 1;
    end
    if (p)       m_pc = t & ~32'h3;
    else if (!s) m_pc = fetched_pc + 4;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},       pc_o,          m_pc);
    check({tag, ".id_instr"}, id_instr_o,    m_instr);
    check({tag, ".id_pc"},    id_pc_o,       m_idpc);
    check({tag, ".id_p4"},    id_pc_plus4_o, m_idp4);
    check({tag, ".valid"},    32'(id_valid_o), 32'(m_valid));
    check({tag, ".fcnt"},     fetch_cnt_o,   cnt_exp(m_fc));
    check({tag, ".scnt"},     stall_cnt_o,   cnt_exp(m_sc));
  endtask

  initial begin
    //        rst   stall flush src   tgt            pc             id_pc          id_p4          v     fc  sc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 0,  0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h0,         32'h4,         1'b1, 1,  0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h4,         32'h8,         1'b1, 2,  0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'h4,         32'h8,         1'b1, 2,  1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'h4,         32'h8,         1'b1, 2,  2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h8,         32'hC,         1'b1, 3,  2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h43,        32'h40,        32'hC,         32'h10,        1'b0, 3,  2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        32'h40,        32'h44,        1'b1, 4,  2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100,       32'h100,       32'h40,        32'h44,        1'b1, 4,  3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h104,       32'h100,       32'h104,       1'b1, 5,  3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h104,       32'h108,       1'b1, 6,  3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 7,  3};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h200,       32'h0,         32'h0,         32'h0,         1'b0, 0,  0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h0,         32'h4,         1'b1, 1,  0};

    rst = 1'b1; stall_i = 0; flush_i = 0; pc_src_i = 0; pc_target_i = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      string tag;
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].src, vecs[i].tgt);
      tag = $sformatf("vec%0d", i);
      check({tag, ".pc"},    pc_o,          vecs[i].pc);
      check({tag, ".id_pc"}, id_pc_o,       vecs[i].id_pc);
      check({tag, ".id_p4"}, id_pc_plus4_o, vecs[i].id_p4);
      check({tag, ".valid"}, 32'(id_valid_o), 32'(vecs[i].valid));
      check({tag, ".instr"}, id_instr_o,    vecs[i].valid ? mem(vecs[i].id_pc) : NOP);
      check({tag, ".fcnt"},  fetch_cnt_o,   cnt_exp(vecs[i].fcnt));
      check({tag, ".scnt"},  stall_cnt_o,   cnt_exp(vecs[i].scnt));
    end

    // Hand sequence: flush while stalled yields a bubble and does not count as a stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_stall.pc",    pc_o,           32'h4);
    check("flush_stall.instr", id_instr_o,     NOP);
    check("flush_stall.valid", 32'(id_valid_o), 32'h0);
    check("flush_stall.id_pc", id_pc_o,        32'h4);
    check("flush_stall.scnt",  stall_cnt_o,    cnt_exp(32'h0));
    check("flush_stall.fcnt",  fetch_cnt_o,    cnt_exp(32'h1));

    // Randomized run against the model
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_model("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      logic r, s, f, p;
      logic [31:0] t;
      r = ($urandom_range(63) == 0);
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(7) == 0);
      p = ($urandom_range(5) == 0);
      t = $urandom();
      if ($urandom_range(15) == 0) t = 32'hFFFF_FFFC | (t & 32'h3);
      drive(r, s, f, p, t);
      model_step(r, s, f, p, t);
      check_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction inserted into IF/ID on a bubble.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  is the reset, synchronous and active-high.
REQ-005 stall_i  in  1  holds the PC and the IF/ID register.
REQ-006 flush_i  in  1  replaces the next IF/ID contents with a bubble.
REQ-007 pc_src_i  in  1  redirects the PC to pc_target_i (taken branch or jump).
REQ-008 pc_target_i  in  32  is the redirect address.
REQ-009 pc_o  out  32  is the current PC and drives the instruction-memory address input.
REQ-010 instr_i  in  32  is the instruction word returned combinationally by instruction memory for pc_o.
REQ-011 id_instr_o  out  32  is the registered instruction to decode.
REQ-012 id_pc_o  out  32  is the registered PC of id_instr_o.
REQ-013 id_pc_plus4_o  out  32  is id_pc_o + 4.
REQ-014 id_valid_o  out  1  is 1 when the IF/ID contents are a real fetched instruction.
REQ-015 fetch_cnt_o  out  32  counts completed fetches (see Configuration).
REQ-016 stall_cnt_o  out  32  counts stalled cycles (see Configuration).

Function
REQ-017 The PC next-value priority SHALL be: rst > pc_src_i > stall_i > sequential (pc_o + 4).
REQ-018 A redirect SHALL load {pc_target_i[31:2], 2'b00}; the low two bits are always cleared.
REQ-019 A redirect SHALL take effect even when stall_i=1 in the same cycle.
REQ-020 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without any flag.
REQ-021 The IF/ID register priority SHALL be: rst > flush_i > stall_i > load.
REQ-022 Load: id_instr_o <= instr_i, id_pc_o <= pc_o, id_pc_plus4_o <= pc_o + 4, id_valid_o <= 1.
REQ-023 Flush: id_instr_o <= NOP_INSTR and id_valid_o <= 0; id_pc_o and id_pc_plus4_o are loaded as for Load.
REQ-024 Stall without flush SHALL leave all id_* outputs unchanged.
REQ-025 Fetch latency SHALL be one cycle: the instruction at pc_o in cycle N appears on id_instr_o in cycle N+1.
REQ-026 pc_o SHALL be the output of a register, with no combinational path from any input.

Reset
REQ-027 On rst=1 at a rising edge: pc_o <= RESET_PC, id_instr_o <= NOP_INSTR, id_pc_o <= 0, id_pc_plus4_o <= 0, id_valid_o <= 0, and both counters <= 0.
REQ-028 rst SHALL override stall_i, flush_i and pc_src_i in the same cycle.
REQ-029 Mid-operation reset SHALL discard any in-flight instruction; the first fetch after reset is from RESET_PC.

Configuration
REQ-030 Macro IF_STAGE_PERF_CNT_EN defined: fetch_cnt_o SHALL increment on every non-reset cycle whose IF/ID action is Load.
REQ-031 With the macro defined: stall_cnt_o SHALL increment on every non-reset cycle with stall_i=1 and flush_i=0.
REQ-032 With the macro defined: both counters SHALL wrap modulo 2^32.
REQ-033 Macro undefined: the counter registers SHALL be absent, and fetch_cnt_o and stall_cnt_o SHALL be tied to 0; all other behaviour is identical.

Structure
REQ-034 NOP_INSTR default value and the PC increment constant (4) SHALL live in the shared package riscv_pkg.
REQ-035 The block SHALL have one sub-module, pc_reg: the PC register with next-PC selection (REQ-017 to REQ-020).
REQ-036 The IF/ID register and the counters SHALL reside in if_stage.

Verification
REQ-037 Reset then 3 free-running cycles, instr_i = mem[pc_o>>2] -> pc_o goes 0, 4, 8, 12; id_pc_o goes 0, 0, 4, 8; id_valid_o goes 0, 1, 1, 1.
REQ-038 stall_i=1 for 2 cycles at pc_o=8 -> pc_o stays 8 and id_* are frozen; with the macro defined, stall_cnt_o rises by 2.
REQ-039 pc_src_i=1, pc_target_i=32'h0000_0043, flush_i=1 -> next pc_o = 32'h0000_0040, id_instr_o = 32'h0000_0013, id_valid_o = 0.
REQ-040 pc_src_i=1 and stall_i=1 together, target 32'h100 -> pc_o = 32'h100 while id_* hold.
REQ-041 Set PC to 32'hFFFF_FFFC, run 1 cycle -> pc_o = 0 and id_pc_plus4_o = 0.
REQ-042 Assert rst during a stall with flush_i=1 and pc_src_i=1 -> all REQ-027 values; next fetch from RESET_PC.
